// File: rtl/btn_input_conditioner.sv
// Push-button front end: two-flop sync, per-channel debounce FSM, one-cycle move strobes
// with same-player rh/lf lock-out. Define AUTOREPEAT_EN to add hold-to-repeat strobes.
module btn_input_conditioner #(
  parameter int N_BTN         = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEB_CYC       = 500000,
  parameter int REP_DELAY_CYC = 12500000,
  parameter int REP_RATE_CYC  = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             btn_any
);

  localparam int MAX_DR  = (DEB_CYC > REP_DELAY_CYC) ? DEB_CYC : REP_DELAY_CYC;
  localparam int MAX_CYC = (MAX_DR > REP_RATE_CYC) ? MAX_DR : REP_RATE_CYC;
  localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  // Press/release is accepted on the edge the count would reach DEB_CYC-1; the
  // entry edge itself is the first stable sample.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] DEB_ARM  = CW'(DEB_CYC - 2);

  localparam logic [N_BTN-1:0] REL_VAL = ACTIVE_LOW ? '1 : '0;

  typedef enum logic [2:0] {
    WAIT_REL,
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_REL
  } state_t;

  logic [N_BTN-1:0] sync1, sync2, synced;
  logic [N_BTN-1:0] req, fire;
  state_t           state [N_BTN];
  logic [CW-1:0]    cnt   [N_BTN];

`ifdef AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_FIRE   = CW'(REP_DELAY_CYC - 1);
  localparam logic [CW-1:0] REP_RELOAD = CW'(REP_DELAY_CYC - REP_RATE_CYC);
  logic [CW-1:0] hold [N_BTN];
`endif

  assign synced = ACTIVE_LOW ? ~sync2 : sync2;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (state[i] == DEB_PRESS && synced[i] && cnt[i] == DEB_ARM) req[i] = 1'b1;
`ifdef AUTOREPEAT_EN
      if (state[i] == PRESSED && synced[i] && hold[i] == REP_FIRE) req[i] = 1'b1;
`endif
    end
  end

  // A player's rh and lf strobing together cancel each other.
  for (genvar p = 0; p < N_BTN / 2; p++) begin : g_lock
    assign fire[2*p]   = req[2*p]   & ~req[2*p+1];
    assign fire[2*p+1] = req[2*p+1] & ~req[2*p];
  end
  if (N_BTN % 2 == 1) begin : g_odd
    assign fire[N_BTN-1] = req[N_BTN-1];
  end

  assign btn_any = |btn_pulse;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= REL_VAL;
      sync2     <= REL_VAL;
      btn_level <= '0;
      btn_pulse <= '0;
      // NOTE: the per-channel arrays are a few flops each, not RAM, so they
      // are reset explicitly to give a defined WAIT_REL start.
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= WAIT_REL;
        cnt[i]   <= '0;
`ifdef AUTOREPEAT_EN
        hold[i]  <= '0;
`endif
      end
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_pulse <= fire;
      for (int i = 0; i < N_BTN; i++) begin
        case (state[i])
          WAIT_REL: begin
            if (synced[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          IDLE: begin
            if (synced[i]) begin
              state[i] <= DEB_PRESS;
              cnt[i]   <= '0;
            end
          end
          DEB_PRESS: begin
            if (!synced[i]) begin
              state[i] <= IDLE;
            end else if (cnt[i] == DEB_ARM) begin
              state[i]     <= PRESSED;
              btn_level[i] <= 1'b1;
`ifdef AUTOREPEAT_EN
              hold[i]      <= '0;
`endif
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          PRESSED: begin
            if (!synced[i]) begin
              state[i] <= DEB_REL;
              cnt[i]   <= '0;
            end
`ifdef AUTOREPEAT_EN
            else if (hold[i] == REP_FIRE) begin
              hold[i] <= REP_RELOAD;
            end else begin
              hold[i] <= hold[i] + CW'(1);
            end
`endif
          end
          DEB_REL: begin
            if (synced[i]) begin
              state[i] <= PRESSED;
`ifdef AUTOREPEAT_EN
              hold[i]  <= '0;
`endif
            end else if (cnt[i] == DEB_ARM) begin
              state[i]     <= IDLE;
              btn_level[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: state[i] <= WAIT_REL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Scoreboard bench for btn_input_conditioner: a run-length reference model predicts
// btn_pulse/btn_level per cycle, a monitor compares; directed scenarios count strobes.
module tb_btn_input_conditioner;

  localparam int N     = 4;
  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 3;
`ifdef AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic         btn_any;

  btn_input_conditioner #(
    .N_BTN(N), .ACTIVE_LOW(1'b0), .DEB_CYC(DEB),
    .REP_DELAY_CYC(DELAY), .REP_RATE_CYC(RATE)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_any(btn_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] pulse;
    logic [N-1:0] level;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pcount [N];
  int   ec = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, ec, act, exp);
    end
  endtask

  // Reference model: a press/release is accepted once the synchronised level has
  // been seen DEB times in a row; a channel is armed only after DEB released samples.
  bit sh1 [N], sh2 [N], prev [N], armed [N], lvl [N];
  int run [N], anchor [N];

  always @(posedge clk) begin : model
    logic [N-1:0] rq, pl, lv;
    bit s;
    int k;
    ec++;
    rq = '0;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        sh1[i] = 0; sh2[i] = 0; prev[i] = 0; run[i] = 0;
        armed[i] = 0; lvl[i] = 0; anchor[i] = 0;
      end else begin
        s = sh2[i];
        sh2[i] = sh1[i];
        sh1[i] = btn_raw[i];
        if (s == prev[i]) begin
          if (run[i] < 100000) run[i]++;
        end else begin
          run[i] = 1;
        end
        prev[i] = s;
        if (!armed[i]) begin
          if (!s && run[i] == DEB) armed[i] = 1;
        end else if (!lvl[i]) begin
          if (s && run[i] == DEB) begin
            lvl[i] = 1; rq[i] = 1'b1; anchor[i] = ec;
          end
        end else if (!s) begin
          if (run[i] == DEB) lvl[i] = 0;
        end else if (run[i] == 1) begin
          anchor[i] = ec;
        end else if (AUTOREP) begin
          k = ec - anchor[i];
          if (k == DELAY || (k > DELAY && (k - DELAY) % RATE == 0)) rq[i] = 1'b1;
        end
      end
      lv[i] = lvl[i];
    end
    pl = rq;
    if (rq[0] && rq[1]) pl[1:0] = 2'b00;
    if (rq[2] && rq[3]) pl[3:2] = 2'b00;
    exp_q.push_back('{pulse: pl, level: lv});
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("btn_pulse", btn_pulse, e.pulse);
      check("btn_level", btn_level, e.level);
      check("btn_any", btn_any, |e.pulse);
    end
    for (int i = 0; i < N; i++) if (btn_pulse[i]) pcount[i]++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) pcount[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = '0;
    clear_counts();
    step(3);
    rst = 1'b0;

    // 1: let WAIT_REL exit, then a clean press on channel 0
    step(DEB);
    clear_counts();
    btn_raw[0] = 1'b1;
    step(10);
    check("s1_pulses_ch0", pcount[0], 1);
    btn_raw[0] = 1'b0;
    step(10);

    // 2: bouncing channel 1 then a steady hold
    clear_counts();
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(10);
    check("s2_pulses_ch1", pcount[1], 1);
    btn_raw[1] = 1'b0;
    step(10);

    // 3: player A lock-out while player B presses alone
    clear_counts();
    btn_raw = 4'b0111;
    step(10);
    check("s3_pulses_ch0", pcount[0], 0);
    check("s3_pulses_ch1", pcount[1], 0);
    check("s3_pulses_ch2", pcount[2], 1);
    btn_raw = '0;
    step(10);

    // 4: key held through reset must be released before it can strobe
    clear_counts();
    btn_raw[3] = 1'b1;
    rst = 1'b1; step(2); rst = 1'b0;
    step(10);
    check("s4_held_no_strobe", pcount[3], 0);
    btn_raw[3] = 1'b0; step(6);
    btn_raw[3] = 1'b1; step(8);
    check("s4_pulses_ch3", pcount[3], 1);
    btn_raw[3] = 1'b0;
    step(10);

    // 5: long hold on channel 2 (repeats only with AUTOREPEAT_EN)
    clear_counts();
    btn_raw[2] = 1'b1; step(30);
    btn_raw[2] = 1'b0; step(10);
    check("s5_pulses_ch2", pcount[2], AUTOREP ? 7 : 1);

    // 6: reset while channel 0 is mid-debounce
    clear_counts();
    btn_raw[0] = 1'b1; step(5);
    rst = 1'b1; step(1); rst = 1'b0;
    step(8);
    check("s6_abort_no_strobe", pcount[0], 0);
    btn_raw[0] = 1'b0; step(6);
    btn_raw[0] = 1'b1; step(8);
    check("s6_pulses_ch0", pcount[0], 1);
    btn_raw[0] = 1'b0;
    step(10);

    // Random phase: slow random toggling with occasional resets
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) btn_raw[i] = ~btn_raw[i];
      rst = ($urandom_range(199) == 0);
      step(1);
    end
    rst = 1'b0;
    btn_raw = '0;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
